// File: rtl/eth_tx_frame_fifo.sv
// Transmit frame FIFO: speculative writes become visible to the reader only on commit.
// Optional macro ETH_TX_FIFO_DROP_EN: overflowing frames are discarded at commit instead of truncated.
module eth_tx_frame_fifo #(
    parameter int unsigned ADDR_W = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [8:0]  wr_d,
    input  logic        wr_chk,
    input  logic        wr_clr,
    output logic        wr_full,
    input  logic        rd_en,
    output logic [8:0]  rd_d,
    output logic        rd_end,
    output logic        rd_valid,
    output logic        rd_empty,
    output logic [15:0] drop_count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PtrOne = {{ADDR_W{1'b0}}, 1'b1};

    logic [8:0]      mem_q [DEPTH];
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] chk_ptr_q, chk_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [8:0]      rd_d_q;
    logic            rd_valid_q;
    logic [15:0]     drop_count_q, drop_count_d;
    logic            framing, clr_eff, do_write, do_read;

`ifdef ETH_TX_FIFO_DROP_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        wr_full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
        rd_empty = (rd_ptr_q == chk_ptr_q);
        framing  = (wr_ptr_q != chk_ptr_q);
`ifdef ETH_TX_FIFO_DROP_EN
        // A commit of an overflowed frame is turned into a discard
        clr_eff  = wr_clr || (wr_chk && ovf_q);
`else
        clr_eff  = wr_clr;
`endif
        do_write = wr_en && !wr_full && !clr_eff;
        do_read  = rd_en && !rd_empty;

        wr_ptr_d     = wr_ptr_q;
        chk_ptr_d    = chk_ptr_q;
        drop_count_d = drop_count_q;
        rd_ptr_d     = do_read ? rd_ptr_q + PtrOne : rd_ptr_q;
`ifdef ETH_TX_FIFO_DROP_EN
        ovf_d        = ovf_q;
`endif

        if (clr_eff) begin
            wr_ptr_d = chk_ptr_q;
            if (framing && drop_count_q != 16'hffff) begin
                drop_count_d = drop_count_q + 16'd1;
            end
`ifdef ETH_TX_FIFO_DROP_EN
            ovf_d = 1'b0;
`endif
        end else begin
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
`ifdef ETH_TX_FIFO_DROP_EN
            if (wr_en && wr_full) begin
                ovf_d = 1'b1;
            end
`endif
            // Commit includes a write made in the same cycle
            if (wr_chk) begin
                chk_ptr_d = wr_ptr_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            chk_ptr_q    <= '0;
            rd_ptr_q     <= '0;
            rd_d_q       <= '0;
            rd_valid_q   <= 1'b0;
            drop_count_q <= '0;
`ifdef ETH_TX_FIFO_DROP_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            chk_ptr_q    <= chk_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_valid_q   <= do_read;
            drop_count_q <= drop_count_d;
`ifdef ETH_TX_FIFO_DROP_EN
            ovf_q        <= ovf_d;
`endif
            if (do_read) begin
                rd_d_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
            end
        end
    end

    assign rd_d       = rd_d_q;
    assign rd_end     = rd_d_q[8];
    assign rd_valid   = rd_valid_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
// Randomized bench for eth_tx_frame_fifo against a queue-based frame model.
module tb_eth_tx_frame_fifo;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
`ifdef ETH_TX_FIFO_DROP_EN
    localparam bit DropEn = 1'b1;
`else
    localparam bit DropEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, wr_chk, wr_clr, rd_en;
    logic [8:0]  wr_d;
    logic        wr_full, rd_end, rd_valid, rd_empty;
    logic [8:0]  rd_d;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    eth_tx_frame_fifo #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_d       (wr_d),
        .wr_chk     (wr_chk),
        .wr_clr     (wr_clr),
        .wr_full    (wr_full),
        .rd_en      (rd_en),
        .rd_d       (rd_d),
        .rd_end     (rd_end),
        .rd_valid   (rd_valid),
        .rd_empty   (rd_empty),
        .drop_count (drop_count)
    );

    int checks   = 0;
    int failures = 0;

    // Model: committed-unread words, pending words, drop counter, overflow flag
    logic [8:0] commit_q[$];
    logic [8:0] pend_q[$];
    int         drop_m;
    bit         ovf_m;
    logic [8:0] exp_rd_d;
    bit         exp_valid;
    int         nread;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "/full"}, 32'(wr_full), 32'(commit_q.size() + pend_q.size() == DEPTH));
        check_eq({tag, "/empty"}, 32'(rd_empty), 32'(commit_q.size() == 0));
        check_eq({tag, "/valid"}, 32'(rd_valid), 32'(exp_valid));
        check_eq({tag, "/rd_d"}, 32'(rd_d), 32'(exp_rd_d));
        check_eq({tag, "/rd_end"}, 32'(rd_end), 32'(exp_rd_d[8]));
        check_eq({tag, "/drops"}, 32'(drop_count), 32'(drop_m));
    endtask

    task automatic step(input string tag, input bit we, input logic [8:0] d, input bit chk,
                        input bit clr, input bit re);
        bit full_m, empty_m, clr_eff;
        @(negedge clk);
        wr_en = we; wr_d = d; wr_chk = chk; wr_clr = clr; rd_en = re;
        full_m  = (commit_q.size() + pend_q.size() == DEPTH);
        empty_m = (commit_q.size() == 0);
        clr_eff = clr || (DropEn && chk && ovf_m);
        @(posedge clk);
        #1;
        if (re && !empty_m) begin
            exp_rd_d  = commit_q.pop_front();
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        if (we && !clr_eff) begin
            if (!full_m) pend_q.push_back(d);
            else if (DropEn) ovf_m = 1'b1;
        end
        if (clr_eff) begin
            if (pend_q.size() > 0 && drop_m < 65535) drop_m++;
            pend_q.delete();
            ovf_m = 1'b0;
        end else if (chk) begin
            foreach (pend_q[i]) commit_q.push_back(pend_q[i]);
            pend_q.delete();
        end
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        wr_en = 0; wr_d = '0; wr_chk = 0; wr_clr = 0; rd_en = 0;
        @(posedge clk);
        #1;
        commit_q.delete();
        pend_q.delete();
        drop_m = 0; ovf_m = 0; exp_rd_d = '0; exp_valid = 0;
        check_outputs(tag);
        check_eq({tag, "/rst_empty"}, 32'(rd_empty), 32'd1);
        check_eq({tag, "/rst_rd_d"}, 32'(rd_d), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        if (pend_q.size() > 0) step({tag, "_clr"}, 0, '0, 0, 1, 0);
        while (commit_q.size() > 0 && guard < 4 * DEPTH) begin
            step(tag, 0, '0, 0, 0, 1);
            guard++;
        end
        check_eq({tag, "/drained"}, 32'(commit_q.size()), 32'd0);
        step({tag, "_idle"}, 0, '0, 0, 0, 0);
    endtask

    initial begin
        int   frames, widx, budget;
        logic [8:0] w;
        rst = 1'b1;
        wr_en = 0; wr_d = '0; wr_chk = 0; wr_clr = 0; rd_en = 0;
        do_reset("reset");

        // Basic frame commit and read-back
        step("f1_w0", 1, 9'h0AA, 0, 0, 0);
        step("f1_w1", 1, 9'h0BB, 0, 0, 0);
        step("f1_w2", 1, 9'h1CC, 0, 0, 0);
        step("f1_chk", 0, '0, 1, 0, 0);
        check_eq("f1_visible", 32'(rd_empty), 32'd0);
        step("f1_r0", 0, '0, 0, 0, 1);
        step("f1_r1", 0, '0, 0, 0, 1);
        step("f1_r2", 0, '0, 0, 0, 1);
        check_eq("f1_last", 32'(rd_d), 32'h1CC);
        step("f1_r3", 0, '0, 0, 0, 1);

        // Abort then a clean 2-word frame
        for (int i = 0; i < 4; i++) step("f2_w", 1, 9'(8'h10 + i), 0, 0, 0);
        step("f2_clr", 0, '0, 0, 1, 0);
        check_eq("f2_drop", 32'(drop_count), 32'd1);
        step("f2b_w0", 1, 9'h021, 0, 0, 0);
        step("f2b_w1", 1, 9'h122, 1, 0, 0);
        drain("f2b_rd");

        // Clear beats same-cycle write and commit
        for (int i = 0; i < 3; i++) step("f3_w", 1, 9'(8'h30 + i), 0, 0, 0);
        step("f3_all", 1, 9'h155, 1, 1, 0);
        check_eq("f3_drop", 32'(drop_count), 32'd2);
        check_eq("f3_empty", 32'(rd_empty), 32'd1);

        // Fill to full, one extra write, then commit
        for (int i = 0; i < DEPTH; i++) step("f4_w", 1, 9'(i + 1), 0, 0, 0);
        check_eq("f4_full", 32'(wr_full), 32'd1);
        step("f4_extra", 1, 9'h1FF, 0, 0, 0);
        step("f4_chk", 0, '0, 1, 0, 0);
        check_eq("f4_empty", 32'(rd_empty), 32'(DropEn));
        drain("f4_rd");

        // Streaming 7-word frames with random concurrent reads
        frames = 0; widx = 0; nread = 0; budget = 0;
        while ((frames < 100 || commit_q.size() > 0) && budget < 20000) begin
            bit we, re, last;
            we   = (frames < 100) && (commit_q.size() + pend_q.size() < DEPTH);
            last = (widx == 6);
            w    = {last, 8'($urandom)};
            re   = ($urandom_range(0, 3) != 0);
            step("stream", we, w, we && last, 0, re);
            if (rd_valid) begin
                check_eq("stream_end", 32'(rd_end), 32'(nread % 7 == 6));
                nread++;
            end
            if (we) begin
                if (last) begin widx = 0; frames++; end
                else widx++;
            end
            budget++;
        end
        check_eq("stream_count", 32'(nread), 32'd700);

        // Random mix of writes, commits, clears and reads, including writes at full
        for (int i = 0; i < 600; i++) begin
            bit we, chk, clr, re;
            we  = ($urandom_range(0, 3) != 0);
            chk = ($urandom_range(0, 9) == 0);
            clr = ($urandom_range(0, 24) == 0);
            re  = ($urandom_range(0, 2) != 0);
            step("rand", we, 9'($urandom), chk, clr, re);
        end

        // Reset mid-frame with a read word on the output
        drain("pre_rst");
        step("m_w0", 1, 9'h0E1, 0, 0, 0);
        step("m_w1", 1, 9'h0E2, 1, 0, 0);
        step("m_w2", 1, 9'h0E3, 0, 0, 0);
        step("m_rd", 0, '0, 0, 0, 1);
        check_eq("m_valid", 32'(rd_valid), 32'd1);
        do_reset("mid_rst");
        check_eq("mid_rst_drop", 32'(drop_count), 32'd0);
        step("post_rst", 0, '0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
